cfg_chain_loader: RTL

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_chain_pkg.sv | 15 +
 rtl/cfg_chain_shifter.sv | 48 ++++
 rtl/cfg_chain_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cfg_chain_pkg.sv
// Shared state encoding and parameter defaults for the configuration chain loader.
package cfg_chain_pkg;

  localparam int CHAIN_LEN_DEF = 64;
  localparam int WORD_W_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    COMMIT
  } state_t;

endpackage

// File: rtl/cfg_chain_shifter.sv
// Word shift register feeding chain_d and capturing chain_q, with its bit index.
module cfg_chain_shifter
  import cfg_chain_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int IW     = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              q_in,
  output logic              next_bit,
  output logic [IW-1:0]     idx,
  output logic [WORD_W-1:0] cap_nxt
);

  logic [WORD_W-1:0] data_r;
  logic [WORD_W-1:0] data_shr;
  logic [WORD_W-1:0] cap_r;

  assign data_shr = data_r >> 1;
  assign next_bit = data_shr[0];

  // Capture word including the bit being sampled this cycle.
  always_comb begin
    cap_nxt      = cap_r;
    cap_nxt[idx] = q_in;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_r <= '0;
      cap_r  <= '0;
      idx    <= '0;
    end else if (load) begin
      data_r <= load_data;
      cap_r  <= '0;
      idx    <= '0;
    end else if (shift) begin
      data_r <= data_shr;
      cap_r  <= cap_nxt;
      idx    <= idx + IW'(1);
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial configuration chain loader: writes host words into the chain while reading
// the old contents back, then commits.
//
// state  | meaning
// IDLE   | waiting for start, chain shows latch output
// LOAD   | waiting for next host word (and a free readback register)
// SHIFT  | shifting one word into the chain, capturing chain_q
// DRAIN  | waiting for the final readback word to be taken
// COMMIT | one-cycle commit pulse, done follows in IDLE
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              chain_d,
  output logic              chain_en,
  output logic              chain_sel,
  input  logic              chain_q,
  output logic              busy,
  output logic              commit,
  output logic              done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t            state;
  logic [CW-1:0]     bits_done;
  logic              sh_load;
  logic              sh_shift;
  logic              sh_next_bit;
  logic [IW-1:0]     sh_idx;
  logic [WORD_W-1:0] sh_cap_nxt;
  logic              out_free;
  logic              chain_last;
  logic              last_bit;

  // in_ready looks at out_ready directly so a word taken this cycle frees the slot at once.
  assign out_free   = out_valid && out_ready;
  assign in_ready   = (state == LOAD) && (!out_valid || out_ready);
  assign sh_load    = in_valid && in_ready;
  assign sh_shift   = (state == SHIFT);
  assign chain_last = (bits_done == CW'(CHAIN_LEN - 1));
  assign last_bit   = (sh_idx == IW'(WORD_W - 1)) || chain_last;

  cfg_chain_shifter #(
    .WORD_W (WORD_W),
    .IW     (IW)
  ) u_shifter (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (sh_load),
    .load_data (in_data),
    .shift     (sh_shift),
    .q_in      (chain_q),
    .next_bit  (sh_next_bit),
    .idx       (sh_idx),
    .cap_nxt   (sh_cap_nxt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      bits_done <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      chain_d   <= 1'b0;
      chain_en  <= 1'b0;
      chain_sel <= 1'b0;
      busy      <= 1'b0;
      commit    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_free) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            bits_done <= '0;
            busy      <= 1'b1;
            chain_sel <= 1'b1;
          end
        end
        LOAD: begin
          if (sh_load) begin
            state    <= SHIFT;
            chain_en <= 1'b1;
            chain_d  <= in_data[0];
          end
        end
        SHIFT: begin
          bits_done <= bits_done + CW'(1);
          if (last_bit) begin
            chain_en  <= 1'b0;
            chain_d   <= 1'b0;
            out_data  <= sh_cap_nxt;
            out_valid <= 1'b1;
            state     <= chain_last ? DRAIN : LOAD;
          end else begin
            chain_d <= sh_next_bit;
          end
        end
        DRAIN: begin
          if (out_free) begin
            state     <= COMMIT;
            commit    <= 1'b1;
            chain_sel <= 1'b0;
          end
        end
        COMMIT: begin
          state  <= IDLE;
          commit <= 1'b0;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
